instr_loader: RTL

- Host-side writer into instruction memory: assembles 16-bit instruction words from UART RX bytes and writes them to sequential instruction-memory addresses.
- Checks each word's opcode field (bits 15:12) against the legal opcode set consumed by the CPU decode stage.
- Holds the CPU in reset while a program is loading and releases it when loading completes.
- Sits between uart_rx and the instruction memory / CPU reset.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/loader_timeout_cnt.sv | 31 +++
 rtl/instr_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, instruction-loader state encoding and framing defaults.
package cpu_pkg;

  localparam logic [3:0] OPC_LDA_IMM    = 4'b0000;
  localparam logic [3:0] OPC_LDA_MEM    = 4'b0001;
  localparam logic [3:0] OPC_STA_MEM    = 4'b0010;
  localparam logic [3:0] OPC_ADD_IMM    = 4'b0011;
  localparam logic [3:0] OPC_ADD_REG    = 4'b0100;
  localparam logic [3:0] OPC_SUB_IMM    = 4'b0101;
  localparam logic [3:0] OPC_SUB_REG    = 4'b0110;
  localparam logic [3:0] OPC_AND_REG    = 4'b0111;
  localparam logic [3:0] OPC_OR_REG     = 4'b1000;
  localparam logic [3:0] OPC_JMP        = 4'b1001;
  localparam logic [3:0] OPC_BAF_REGSUB = 4'b1010;
  localparam logic [3:0] OPC_MAX_LEGAL  = OPC_BAF_REGSUB;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_HI    = 3'd2;
  localparam logic [2:0] ST_LO    = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  localparam logic [7:0] START_BYTE_DEFAULT = 8'hA5;

  // Opcodes above the last decoded one would trap the CPU, so reject them at load time.
  function automatic logic opc_legal(input logic [3:0] opc);
    return opc <= OPC_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/loader_timeout_cnt.sv
// Inter-byte watchdog for the instruction loader; only built when INSTR_LOADER_TIMEOUT_EN is defined.
`ifdef INSTR_LOADER_TIMEOUT_EN
module loader_timeout_cnt #(
  parameter int unsigned LIMIT = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt;

  assign expire_c = (cnt == CNT_W'(LIMIT - 1));

  // Saturates at the limit so a stuck frame keeps reporting expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/instr_loader.sv
// Loads framed UART bytes into instruction memory as 16-bit words and holds the CPU in reset until done.
// Optional inter-byte timeout: define INSTR_LOADER_TIMEOUT_EN.
module instr_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [7:0]  START_BYTE  = START_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  output logic              o_cpu_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [7:0]        o_count
);

  localparam int unsigned MAX_WORDS = (ADDR_W >= 8) ? 32'd255 : (32'd1 << ADDR_W);

  logic [2:0]        state, state_nxt;
  logic [7:0]        hi, hi_nxt;
  logic [7:0]        n_words, n_nxt;
  logic [7:0]        count_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt, mem_addr_nxt;
  logic [15:0]       wdata_nxt, word_c;
  logic              is_start_c, last_word_c, timeout_c;

  assign is_start_c  = i_rx_valid && (i_rx_data == START_BYTE);
  assign word_c      = {hi, i_rx_data};
  assign last_word_c = ((o_count + 8'd1) == n_words);

`ifdef INSTR_LOADER_TIMEOUT_EN
  logic to_clr, to_en, to_expire_c;

  assign to_clr = i_rx_valid || ((state_nxt == ST_COUNT) && (state != ST_COUNT));
  assign to_en  = (state == ST_COUNT) || (state == ST_HI) || (state == ST_LO);

  loader_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clr      (to_clr),
    .en       (to_en),
    .expire_c (to_expire_c)
  );

  assign timeout_c = to_expire_c;
`else
  logic unused_timeout;

  assign unused_timeout = ^32'(TIMEOUT_CYC);
  assign timeout_c      = 1'b0;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    hi_nxt    = hi;
    n_nxt     = n_words;
    addr_nxt  = addr;
    count_nxt = o_count;
    wdata_nxt = o_mem_wdata;
    case (state)
      ST_IDLE: begin
        if (is_start_c) state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (i_rx_valid) begin
          if ((i_rx_data == 8'd0) || (32'(i_rx_data) > MAX_WORDS)) begin
            state_nxt = ST_ERROR;
          end else begin
            n_nxt     = i_rx_data;
            addr_nxt  = '0;
            count_nxt = '0;
            state_nxt = ST_HI;
          end
        end else if (timeout_c) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_HI: begin
        if (i_rx_valid) begin
          hi_nxt    = i_rx_data;
          state_nxt = ST_LO;
        end else if (timeout_c) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_LO: begin
        if (i_rx_valid) begin
          if (!opc_legal(word_c[15:12])) begin
            state_nxt = ST_ERROR;
          end else begin
            wdata_nxt = word_c;
            state_nxt = ST_WRITE;
          end
        end else if (timeout_c) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_WRITE: begin
        addr_nxt  = addr + ADDR_W'(1);
        count_nxt = o_count + 8'd1;
        // A byte landing here is the next high byte unless the frame is already complete.
        if (last_word_c) begin
          state_nxt = ST_DONE;
        end else if (i_rx_valid) begin
          hi_nxt    = i_rx_data;
          state_nxt = ST_LO;
        end else begin
          state_nxt = ST_HI;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (is_start_c) state_nxt = ST_COUNT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mem_addr_nxt = (state_nxt == ST_WRITE) ? addr : o_mem_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      hi          <= '0;
      n_words     <= '0;
      addr        <= '0;
      o_count     <= '0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_cpu_rst_n <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_nxt;
      hi          <= hi_nxt;
      n_words     <= n_nxt;
      addr        <= addr_nxt;
      o_count     <= count_nxt;
      o_mem_we    <= (state_nxt == ST_WRITE);
      o_mem_addr  <= mem_addr_nxt;
      o_mem_wdata <= wdata_nxt;
      o_cpu_rst_n <= (state_nxt == ST_DONE);
      o_busy      <= (state_nxt == ST_COUNT) || (state_nxt == ST_HI) ||
                     (state_nxt == ST_LO) || (state_nxt == ST_WRITE);
      o_done      <= (state_nxt == ST_DONE);
      o_err       <= (state_nxt == ST_ERROR);
    end
  end

endmodule
